cache_line_write_merge: RTL
===========================

// Module: cache_line_write_merge
// PURPOSE
//  Write-side counterpart of the cache read word mux.
//  On a CPU store that hits, it takes the 128-bit line of the hit way and merges the 16-bit
//    store word (byte-masked) at the addressed word slot.
//  It then drives the merged line and a one-cycle write strobe to the selected way's data
//    array, and returns mem_resp.
//  It sits between the cache control FSM and the two data arrays in the 2-way L1.
// PARAMETERS
//  LINE_WIDTH  128  bits per cache line (8 words)
//  WORD_WIDTH  16   bits per CPU word (lc3b_word)
// PORTS
//  clk              in   1    system clock, all state updates on rising edge
//  rst              in   1    synchronous, active-high reset
//  mem_write        in   1    CPU store request; held high until mem_resp seen
//  hit              in   1    tag match this cycle (either way)
//  way_select       in   1    0 = way0, 1 = way1 (hit way)
//  offset           in   4    byte offset in line; [3:1] word slot, [0] ignored
//  mem_wdata        in   16   store data (lc3b_word)
//  mem_byte_enable  in   2    [0] = low byte lane, [1] = high byte lane
//  line_in0         in   128  current way0 line (lc3b_data)
//  line_in1         in   128  current way1 line (lc3b_data)
//  line_out         out  128  merged line to data arrays
//  data_write0      out  1    way0 data array write strobe
//  data_write1      out  1    way1 data array write strobe
//  dirty_set        out  1    set dirty bit of the selected way; coincident with strobe
//  mem_resp         out  1    store complete, 1-cycle pulse
// BEHAVIOUR
//  Reset values
//  - line_out = 0, data_write0/1 = 0, dirty_set = 0, mem_resp = 0, state = IDLE.
//  FSM states: IDLE -> MERGE -> COMMIT -> DONE -> IDLE.
//  - IDLE
//    - When mem_write && hit: latch way_select, offset[3:1], mem_wdata, mem_byte_enable.
//    - In the same cycle, latch line_in0 (way 0) or line_in1 (way 1) into the line register.
//    - Go to MERGE.
//    - mem_write && !hit: stay in IDLE; misses are handled elsewhere.
//  - MERGE
//    - Word slot k = offset[3:1] occupies bits [16k+15:16k].
//    - byte_enable[0] replaces bits [16k+7:16k] with wdata[7:0].
//    - byte_enable[1] replaces bits [16k+15:16k+8] with wdata[15:8].
//    - All other bits are unchanged. Go to COMMIT.
//  - COMMIT
//    - line_out = merged line (registered).
//    - data_write{way} = 1 for exactly this cycle; the other strobe stays 0.
//    - dirty_set = 1 unless byte_enable == 2'b00. Go to DONE.
//  - DONE
//    - mem_resp = 1 for exactly this cycle. Go to IDLE unconditionally.
//  Timing and hold rules
//  - Latency: request accepted in cycle 0, strobe in cycle 2, mem_resp in cycle 3.
//  - line_out holds its last merged value outside COMMIT; strobes are the only qualifier.
//  - Request inputs are ignored after acceptance. Changes to offset, wdata or way during
//    MERGE/COMMIT/DONE have no effect.
//  - mem_write still high in the cycle after DONE with hit: treated as a new store.
//    The CPU must drop mem_write on mem_resp.
//  Boundary cases
//  - byte_enable == 2'b00: line is rewritten unchanged, strobe still pulses, dirty_set = 0,
//    mem_resp still issued.
//  - Slot 7 uses bits [127:112], the full top word, both lanes.
//  - rst in any state: next cycle is IDLE. No strobe, dirty_set or mem_resp is emitted for
//    the aborted store.
//  - rst and mem_write together: rst wins; the request is not accepted.
// TESTING
//  1. Way0, offset 4'h0, be 2'b11, wdata 16'hBEEF, line_in0 all 0.
//     -> cycle 2: line_out = 128'h...0000_BEEF, data_write0 = 1, dirty_set = 1.
//     -> cycle 3: mem_resp = 1.
//  2. Way1, offset 4'hE, be 2'b11, wdata 16'h1234, line_in1 all F.
//     -> line_out[127:112] = 16'h1234, rest all F; data_write1 only.
//  3. Way0, offset 4'h5 (slot 2), be 2'b10, wdata 16'hAB00, line_in0 = 128'h0.
//     -> line_out[47:40] = 8'hAB, all other bits 0.
//  4. be 2'b00, offset 4'h6, line_in0 = known pattern.
//     -> line_out equals pattern, data_write0 = 1, dirty_set = 0, mem_resp = 1.
//  5. mem_write = 1, hit = 0 for 5 cycles.
//     -> no strobe, no mem_resp, state stays IDLE.
//  6. Assert rst during COMMIT.
//     -> next cycle all outputs 0, no mem_resp.
//     -> a fresh hit store afterwards completes normally in 3 cycles.

Source files
------------

// File: rtl/cache_line_write_merge.sv
// Store-hit write merge: byte-masked 16-bit store into the hit way's 128-bit line, then write strobe and response.
// Latency: accept in cycle 0, data_write/dirty_set in cycle 2, mem_resp in cycle 3.
// Backpressure: none; the CPU holds mem_write until mem_resp and must drop it on that pulse.
module cache_line_write_merge #(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_write,
    input  logic                  hit,
    input  logic                  way_select,
    input  logic [3:0]            offset,
    input  logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [1:0]            mem_byte_enable,
    input  logic [LINE_WIDTH-1:0] line_in0,
    input  logic [LINE_WIDTH-1:0] line_in1,
    output logic [LINE_WIDTH-1:0] line_out,
    output logic                  data_write0,
    output logic                  data_write1,
    output logic                  dirty_set,
    output logic                  mem_resp
);

    localparam int NUM_WORDS = LINE_WIDTH / WORD_WIDTH;
    localparam int BYTE_W    = WORD_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MERGE  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_way;
    logic [2:0]            r_slot;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [1:0]            r_be;
    logic [LINE_WIDTH-1:0] r_line;
    logic [LINE_WIDTH-1:0] r_line_out;
    logic [LINE_WIDTH-1:0] w_merged;
    logic                  w_accept;

    assign w_accept = (r_state == IDLE) && mem_write && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_way      <= 1'b0;
            r_slot     <= 3'd0;
            r_wdata    <= '0;
            r_be       <= 2'b00;
            r_line     <= '0;
            r_line_out <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_way   <= way_select;
                r_slot  <= offset[3:1];
                r_wdata <= mem_wdata;
                r_be    <= mem_byte_enable;
                r_line  <= way_select ? line_in1 : line_in0;
            end
            // line_out only changes on entry to COMMIT and holds afterwards
            if (r_state == MERGE) begin
                r_line_out <= w_merged;
            end
        end
    end

    always_comb begin
        w_merged = r_line;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_slot == 3'(k)) begin
                if (r_be[0]) w_merged[k*WORD_WIDTH +: BYTE_W]          = r_wdata[BYTE_W-1:0];
                if (r_be[1]) w_merged[k*WORD_WIDTH + BYTE_W +: BYTE_W] = r_wdata[WORD_WIDTH-1:BYTE_W];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        data_write0  = 1'b0;
        data_write1  = 1'b0;
        dirty_set    = 1'b0;
        mem_resp     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = MERGE;
            end
            MERGE: begin
                w_next_state = COMMIT;
            end
            COMMIT: begin
                data_write0  = ~r_way;
                data_write1  = r_way;
                dirty_set    = (r_be != 2'b00);
                w_next_state = DONE;
            end
            DONE: begin
                mem_resp     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign line_out = r_line_out;

endmodule
